// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the multiplier and divider datapaths.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam logic signed [9:0] FP_BIAS    = 10'sd127;
    localparam logic [7:0]        FP_EXP_MAX = 8'hFF;
    localparam logic [31:0]       FP_QNAN    = 32'h7FC00000;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StNorm,
        StFinish
    } mul_state_e;

    // Outcome of operand classification, decided when start is accepted.
    typedef enum logic [1:0] {
        SpNone,
        SpNan,
        SpInf,
        SpZero
    } mul_special_e;

endpackage

// File: rtl/fpu_classify.sv
// Combinational single-precision operand decode. Denormals (exp == 0) report as zero.
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [31:0] op_i,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o
);

    fp32_t op;

    // Field-level decode of one operand.
    always_comb begin
        op        = op_i;
        is_zero_o = (op.exp == 8'h00);
        is_inf_o  = (op.exp == FP_EXP_MAX) && (op.mant == 23'd0);
        is_nan_o  = (op.exp == FP_EXP_MAX) && (op.mant != 23'd0);
    end

endmodule

// File: rtl/mul_fpu_seq.sv
// Sequential IEEE-754 single-precision multiplier, one product bit per clock.
// Optional build macro MUL_FPU_ROUND_EN selects round-to-nearest-even; without it
// the mantissa is truncated (round toward zero).
module mul_fpu_seq
    import fpu_pkg::*;
#(
    parameter int unsigned ITER_BITS = 5,
    parameter logic [31:0] QNAN_VAL  = FP_QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        nan_error
);

    localparam logic [ITER_BITS-1:0] LAST_ITER = ITER_BITS'(23);

    mul_state_e            state_q;
    mul_special_e          special_q;
    mul_special_e          special_d;
    logic [ITER_BITS-1:0]  iter_q;
    logic [47:0]           acc_q;
    logic [47:0]           mcand_q;
    logic [23:0]           mplier_q;
    logic [7:0]            ea_q;
    logic [7:0]            eb_q;
    logic                  sign_q;

    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;

    fp32_t op_a;
    fp32_t op_b;

    logic signed [9:0] exp_sum;
    logic signed [9:0] exp_n;
    logic [22:0]       mant_n;
    logic [31:0]       norm_result;
    logic [31:0]       special_result;

    fpu_classify u_class_a (
        .op_i      (a),
        .is_zero_o (a_zero),
        .is_inf_o  (a_inf),
        .is_nan_o  (a_nan)
    );

    fpu_classify u_class_b (
        .op_i      (b),
        .is_zero_o (b_zero),
        .is_inf_o  (b_inf),
        .is_nan_o  (b_nan)
    );

    // Special-case decision on the live operands, used only when start is accepted.
    always_comb begin
        op_a = a;
        op_b = b;
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            special_d = SpNan;
        end else if (a_inf || b_inf) begin
            special_d = SpInf;
        end else if (a_zero || b_zero) begin
            special_d = SpZero;
        end else begin
            special_d = SpNone;
        end
    end

    // Normalise, round and range-check the finished 48-bit product.
    always_comb begin
        exp_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - FP_BIAS;
        if (acc_q[47]) begin
            mant_n = acc_q[46:24];
            exp_n  = exp_sum + 10'sd1;
        end else begin
            mant_n = acc_q[45:23];
            exp_n  = exp_sum;
        end
`ifdef MUL_FPU_ROUND_EN
        begin : g_round
            logic        guard;
            logic        rnd;
            logic        sticky;
            logic [23:0] mant_inc;
            if (acc_q[47]) begin
                guard  = acc_q[23];
                rnd    = acc_q[22];
                sticky = |acc_q[21:0];
            end else begin
                guard  = acc_q[22];
                rnd    = acc_q[21];
                sticky = |acc_q[20:0];
            end
            mant_inc = {1'b0, mant_n} + 24'd1;
            if (guard && (rnd || sticky || mant_n[0])) begin
                // Carry-out leaves mant_inc[22:0] == 0, i.e. 1.0 at the next exponent.
                mant_n = mant_inc[22:0];
                if (mant_inc[23]) begin
                    exp_n = exp_n + 10'sd1;
                end
            end
        end
`endif
        if (exp_n >= 10'sd255) begin
            norm_result = {sign_q, FP_EXP_MAX, 23'd0};
        end else if (exp_n <= 10'sd0) begin
            norm_result = {sign_q, 31'd0};
        end else begin
            norm_result = {sign_q, exp_n[7:0], mant_n};
        end
    end

`ifndef MUL_FPU_ROUND_EN
    // Discarded product bits only matter when rounding is built in.
    logic unused_low_bits;
    assign unused_low_bits = ^acc_q[22:0];
`endif

    // Result for NaN/Inf/zero operands, selected by the stored classification.
    always_comb begin
        special_result = QNAN_VAL;
        case (special_q)
            SpInf:   special_result = {sign_q, FP_EXP_MAX, 23'd0};
            SpZero:  special_result = {sign_q, 31'd0};
            default: special_result = QNAN_VAL;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            special_q <= SpNone;
            iter_q    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            ea_q      <= '0;
            eb_q      <= '0;
            sign_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            nan_error <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_q    <= op_a.sign ^ op_b.sign;
                        ea_q      <= op_a.exp;
                        eb_q      <= op_b.exp;
                        mcand_q   <= {24'd0, 1'b1, op_a.mant};
                        mplier_q  <= {1'b1, op_b.mant};
                        acc_q     <= '0;
                        iter_q    <= '0;
                        special_q <= special_d;
                        busy      <= 1'b1;
                        state_q   <= (special_d == SpNone) ? StMult : StFinish;
                    end
                end
                StMult: begin
                    acc_q    <= acc_q + (mplier_q[0] ? mcand_q : 48'd0);
                    mplier_q <= mplier_q >> 1;
                    mcand_q  <= mcand_q << 1;
                    iter_q   <= iter_q + ITER_BITS'(1);
                    if (iter_q == LAST_ITER) begin
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    result    <= norm_result;
                    nan_error <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StFinish;
                end
                StFinish: begin
                    // Normal results were registered in NORM; special ones land here.
                    if (special_q != SpNone) begin
                        result    <= special_result;
                        nan_error <= (special_q == SpNan);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        done <= 1'b0;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_fpu_seq.sv
// Self-checking bench for mul_fpu_seq: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_mul_fpu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        nan_error;

    int checks = 0;
    int errors = 0;

    mul_fpu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .nan_error (nan_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product of the significands, then scaling and rounding.
    function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] res, output logic nan,
                                    output logic special);
        logic [7:0]      ex, ey;
        logic [22:0]     mx, my;
        logic            s, xz, yz, xi, yi, xn, yn;
        longint unsigned p, kept, rem;
        int              e, sh;
        ex = x[30:23]; ey = y[30:23]; mx = x[22:0]; my = y[22:0];
        s  = x[31] ^ y[31];
        xz = (ex == 0); yz = (ey == 0);
        xi = (ex == 255) && (mx == 0); yi = (ey == 255) && (my == 0);
        xn = (ex == 255) && (mx != 0); yn = (ey == 255) && (my != 0);
        nan = 1'b0;
        special = 1'b1;
        if (xn || yn || (xz && yi) || (xi && yz)) begin
            res = 32'h7FC00000; nan = 1'b1;
        end else if (xi || yi) begin
            res = {s, 8'hFF, 23'd0};
        end else if (xz || yz) begin
            res = {s, 31'd0};
        end else begin
            special = 1'b0;
            p  = longint'({1'b1, mx}) * longint'({1'b1, my});
            e  = int'(ex) + int'(ey) - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end
            kept = p >> sh;
            rem  = p - (kept << sh);
`ifdef MUL_FPU_ROUND_EN
            if (rem > (64'd1 << (sh - 1)) ||
                (rem == (64'd1 << (sh - 1)) && kept[0])) begin
                kept = kept + 1;
            end
            if (kept == (64'd1 << 24)) begin
                kept = kept >> 1;
                e    = e + 1;
            end
`else
            rem = 0;
`endif
            if (e >= 255)     res = {s, 8'hFF, 23'd0};
            else if (e <= 0)  res = {s, 31'd0};
            else              res = {s, e[7:0], kept[22:0]};
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        int unsigned sel;
        sel = $urandom_range(0, 9);
        m   = 23'($urandom);
        case (sel)
            0: e = 8'h00;
            1: begin e = 8'hFF; m = '0; end
            2: begin e = 8'hFF; if (m == 0) m = 23'd1; end
            3: e = 8'($urandom_range(1, 40));
            4: e = 8'($urandom_range(200, 254));
            5: begin e = 8'($urandom_range(100, 150)); m = '1; end
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom), e, m};
    endfunction

    // One full transaction; lat counts edges from acceptance through the edge raising done.
    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                         output logic [31:0] r, output logic n,
                         output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; a = oa; b = ob;
        @(posedge clk); #1;
        start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 64) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check_val("done_seen", {31'd0, done}, 32'd1);
        check_val("busy_at_done", {31'd0, busy}, 32'd0);
        r = result;
        n = nan_error;
        @(posedge clk); #1;
    endtask

    logic [31:0] r, exp_r;
    logic        n, exp_n, exp_sp;
    int          lat, bc;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check_val("rst_busy",   {31'd0, busy},      32'd0);
        check_val("rst_done",   {31'd0, done},      32'd0);
        check_val("rst_result", result,             32'd0);
        check_val("rst_nan",    {31'd0, nan_error}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic 1.5 * 2.0
        do_op(32'h3FC00000, 32'h40000000, r, n, lat, bc);
        check_val("basic_res", r, 32'h40400000);
        check_val("basic_nan", {31'd0, n}, 32'd0);
        check_val("basic_lat", lat, 32'd26);
        check_val("basic_busy_cycles", bc, 32'd25);
        repeat (3) @(posedge clk);
        #1 check_val("result_held", result, 32'h40400000);

        // Rounding
        do_op(32'h3FC00001, 32'h3FC00001, r, n, lat, bc);
`ifdef MUL_FPU_ROUND_EN
        check_val("round_res", r, 32'h40100002);
`else
        check_val("round_res", r, 32'h40100001);
`endif

        // Invalid and zero
        do_op(32'h00000000, 32'h7F800000, r, n, lat, bc);
        check_val("inv_res", r, 32'h7FC00000);
        check_val("inv_nan", {31'd0, n}, 32'd1);
        check_val("inv_lat", lat, 32'd2);
        do_op(32'h40400000, 32'h00000000, r, n, lat, bc);
        check_val("zero_res", r, 32'h00000000);
        check_val("zero_nan", {31'd0, n}, 32'd0);

        // Overflow with sign, underflow
        do_op(32'h7F000000, 32'hC0000000, r, n, lat, bc);
        check_val("ovf_res", r, 32'hFF800000);
        do_op(32'h00800000, 32'h00800000, r, n, lat, bc);
        check_val("unf_res", r, 32'h00000000);

        // Start pulses at E5 and E20 during an operation are ignored
        begin
            int dones;
            logic [31:0] got;
            dones = 0; got = '0;
            @(negedge clk);
            start = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                start = (k == 5 || k == 20);
                a = 32'h40400000; b = 32'h40400000;
                @(posedge clk); #1;
                if (done) begin
                    dones++;
                    got = result;
                end
            end
            start = 1'b0;
            check_val("hs_done_count", dones, 32'd1);
            check_val("hs_res", got, 32'h40400000);
        end

        // Start held high: back-to-back operations
        begin
            int first_done, first_fall, second_done;
            logic seen;
            first_done = -1; first_fall = -1; second_done = -1; seen = 1'b0;
            @(negedge clk);
            start = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
            for (int k = 0; k < 90 && second_done < 0; k++) begin
                @(posedge clk); #1;
                if (done && first_done < 0) first_done = k;
                else if (!done && first_done >= 0 && first_fall < 0) first_fall = k;
                else if (done && first_fall >= 0 && second_done < 0) second_done = k;
            end
            @(negedge clk);
            start = 1'b0;
            check_val("held_first_done", first_done, 32'd25);
            check_val("held_gap", second_done - first_fall, 32'd26);
            check_val("held_res", result, 32'h40400000);
            repeat (2) @(posedge clk);
        end

        // Asynchronous reset in the middle of MULT
        @(negedge clk);
        start = 1'b1; a = 32'h3FC00001; b = 32'h3FC00001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 check_val("mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy",   {31'd0, busy},      32'd0);
        check_val("mid_rst_done",   {31'd0, done},      32'd0);
        check_val("mid_rst_result", result,             32'd0);
        check_val("mid_rst_nan",    {31'd0, nan_error}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h3FC00000, 32'h40000000, r, n, lat, bc);
        check_val("post_rst_res", r, 32'h40400000);

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = rand_op();
            rb = rand_op();
            ref_mul(ra, rb, exp_r, exp_n, exp_sp);
            do_op(ra, rb, r, n, lat, bc);
            check_val($sformatf("rand%0d_res a=%08h b=%08h", i, ra, rb), r, exp_r);
            check_val($sformatf("rand%0d_nan", i), {31'd0, n}, {31'd0, exp_n});
            check_val($sformatf("rand%0d_lat", i), lat, exp_sp ? 32'd2 : 32'd26);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
